pwm_duty_ctrl: RTL and testbench

Sequencing controller for the PWM lab path. Takes the single-press pulses from two push-button debouncers (up / down), converts them into saturating duty-cycle steps, and owns the PWM counter that applies the new duty only at a period boundary. Sits between the debouncer outputs and the LED/motor PWM pin on the board top level.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/btn_rise_sync.sv | 28 ++
 rtl/pwm_duty_ctrl.sv | 107 ++++++++++
 tb/tb_pwm_duty_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and derived constants for the PWM lab path.
// The duty controller, PWM generator and board top level all import this package.
package pwm_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_STEP      = 16;
   localparam int unsigned DEF_INIT_DUTY = 0;

   // Largest value representable in a width-bit duty or counter.
   function automatic int unsigned max_of(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   typedef enum logic {
      StIdle,
      StPending
   } duty_state_e;

endpackage

// File: rtl/btn_rise_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces a single-cycle rise strobe per press, however long the press lasts.
module btn_rise_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= btn;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_comb begin
      rise = s2_q & ~s3_q;
   end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Turns up/down press pulses into saturating duty steps and runs the PWM counter.
// A new target is only applied to the counter at the end of a period.
module pwm_duty_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned STEP      = DEF_STEP,
   parameter int unsigned INIT_DUTY = DEF_INIT_DUTY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_pb,
   input  logic             down_pb,
   output logic             pwm_out,
   output logic [WIDTH-1:0] duty,
   output logic [WIDTH-1:0] target,
   output logic             pending,
   output logic             period_end
);

   localparam int unsigned      MAX      = max_of(WIDTH);
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(MAX - 1);
   localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT_DUTY);

   logic             up_rise, down_rise;
   logic [WIDTH-1:0] cnt_q, duty_q, target_q, target_d;
   logic [WIDTH:0]   up_sum;
   logic             pwm_q;
   logic             target_chg;
   duty_state_e      state_q, state_d;

   btn_rise_sync u_up_sync (
      .clk  (clk),
      .rst  (rst),
      .btn  (up_pb),
      .rise (up_rise)
   );

   btn_rise_sync u_down_sync (
      .clk  (clk),
      .rst  (rst),
      .btn  (down_pb),
      .rise (down_rise)
   );

   // Extra sum bit keeps the saturation compare exact near MAX.
   always_comb begin
      up_sum   = {1'b0, target_q} + {1'b0, STEP_V};
      target_d = target_q;
      if (up_rise && !down_rise) begin
         target_d = (up_sum > {1'b0, MAX_V}) ? MAX_V : up_sum[WIDTH-1:0];
      end else if (down_rise && !up_rise) begin
         target_d = (target_q < STEP_V) ? '0 : target_q - STEP_V;
      end
      target_chg = (target_d != target_q);
   end

   always_comb begin
      period_end = (cnt_q == LAST_CNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         duty_q   <= INIT_V;
         target_q <= INIT_V;
         pwm_q    <= 1'b0;
      end else begin
         target_q <= target_d;
         pwm_q    <= (cnt_q < duty_q);
         if (period_end) begin
            cnt_q  <= '0;
            duty_q <= target_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A change landing on the boundary cycle keeps us pending for one more period.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (target_chg) state_d = StPending;
         StPending: if (period_end && !target_chg) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      pending = (state_q == StPending);
      pwm_out = pwm_q;
      duty    = duty_q;
      target  = target_q;
   end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl with WIDTH=8, STEP=16, INIT_DUTY=0.
// Table-driven press vectors plus hand-written boundary and reset sequences.
module tb_pwm_duty_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       up_pb = 1'b0;
   logic       down_pb = 1'b0;
   logic       pwm_out;
   logic [7:0] duty;
   logic [7:0] target;
   logic       pending;
   logic       period_end;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic up;
      logic down;
      int   exp_target;
   } vec_t;

   typedef struct {
      string name;
      int    val;
   } exp_t;

   vec_t vecs[34];
   exp_t sb[$];

   pwm_duty_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .up_pb      (up_pb),
      .down_pb    (down_pb),
      .pwm_out    (pwm_out),
      .duty       (duty),
      .target     (target),
      .pending    (pending),
      .period_end (period_end)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input string name, input int val);
      exp_t e;
      e.name = name;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input int act);
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk(e.name, act, e.val);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic press(input logic u, input logic d, input int width);
      up_pb   = u;
      down_pb = d;
      repeat (width) tick();
      up_pb   = 1'b0;
      down_pb = 1'b0;
      repeat (3) tick();
   endtask

   // Stops on the sample where period_end is high, then steps over that boundary edge.
   task automatic pass_boundary();
      int n;
      n = 0;
      while (!period_end && n < 300) begin
         tick();
         n++;
      end
      chk("period_end_seen", int'(period_end), 1);
      tick();
   endtask

   task automatic count_pwm(output int hi);
      hi = 0;
      for (int i = 0; i < 255; i++) begin
         if (pwm_out) hi++;
         tick();
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_duty"}, int'(duty), 0);
      chk({tag, "_target"}, int'(target), 0);
      chk({tag, "_pwm"}, int'(pwm_out), 0);
      chk({tag, "_pending"}, int'(pending), 0);
      chk({tag, "_period_end"}, int'(period_end), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hi;
      int pe_cnt;
      int pe_first;
      int v;

      for (int i = 0; i < 17; i++) begin
         v = 16 * (i + 1);
         vecs[i].up         = 1'b1;
         vecs[i].down       = 1'b0;
         vecs[i].exp_target = (v > 255) ? 255 : v;
      end
      for (int i = 0; i < 17; i++) begin
         v = 255 - 16 * (i + 1);
         vecs[17 + i].up         = 1'b0;
         vecs[17 + i].down       = 1'b1;
         vecs[17 + i].exp_target = (v < 0) ? 0 : v;
      end

      // Reset state and a quiet period at duty 0.
      do_reset();
      chk_reset_state("rst0");
      pe_cnt   = 0;
      pe_first = -1;
      hi       = 0;
      for (int i = 0; i < 510; i++) begin
         if (period_end) begin
            pe_cnt++;
            if (pe_first < 0) pe_first = i;
         end
         if (pwm_out) hi++;
         tick();
      end
      chk("rst_pe_count", pe_cnt, 2);
      chk("rst_pe_first", pe_first, 254);
      chk("rst_pwm_high", hi, 0);

      // Three long up pulses.
      for (int i = 0; i < 3; i++) begin
         push_exp("stepup_target", 16 * (i + 1));
         press(1'b1, 1'b0, 500);
         pop_cmp(int'(target));
      end
      pass_boundary();
      chk("stepup_duty", int'(duty), 48);
      chk("stepup_pending", int'(pending), 0);
      tick();
      count_pwm(hi);
      chk("stepup_pwm_high", hi, 48);

      // Saturation up, full-on PWM, then saturation down.
      do_reset();
      chk_reset_state("rst1");
      for (int i = 0; i < 17; i++) begin
         push_exp("sat_up_target", vecs[i].exp_target);
         press(vecs[i].up, vecs[i].down, 5);
         pop_cmp(int'(target));
      end
      pass_boundary();
      chk("sat_duty", int'(duty), 255);
      tick();
      count_pwm(hi);
      chk("sat_pwm_high", hi, 255);
      for (int i = 17; i < 34; i++) begin
         push_exp("sat_down_target", vecs[i].exp_target);
         press(vecs[i].up, vecs[i].down, 5);
         pop_cmp(int'(target));
      end

      // Simultaneous up and down at target 32.
      press(1'b1, 1'b0, 5);
      press(1'b1, 1'b0, 5);
      chk("simul_pre_target", int'(target), 32);
      pass_boundary();
      chk("simul_pre_pending", int'(pending), 0);
      press(1'b1, 1'b1, 5);
      chk("simul_target", int'(target), 32);
      chk("simul_pending", int'(pending), 0);

      // Rise landing on the period_end cycle.
      do_reset();
      press(1'b1, 1'b0, 5);
      repeat (244) tick();
      chk("bnd_pe_early", int'(period_end), 0);
      chk("bnd_pre_target", int'(target), 16);
      chk("bnd_pre_duty", int'(duty), 0);
      up_pb = 1'b1;
      tick();
      tick();
      chk("bnd_pe_on_rise", int'(period_end), 1);
      push_exp("bnd_duty", 16);
      push_exp("bnd_target", 32);
      push_exp("bnd_pending", 1);
      tick();
      pop_cmp(int'(duty));
      pop_cmp(int'(target));
      pop_cmp(int'(pending));
      repeat (3) tick();
      up_pb = 1'b0;
      pass_boundary();
      chk("bnd_next_duty", int'(duty), 32);
      chk("bnd_next_pending", int'(pending), 0);

      // Reset mid-period with up held.
      do_reset();
      for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 5);
      pass_boundary();
      chk("mid_duty", int'(duty), 128);
      repeat (100) tick();
      chk("mid_pwm", int'(pwm_out), 1);
      up_pb = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_reset_state("mid_rst");
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rel_e1_target", int'(target), 0);
      tick();
      chk("mid_rel_e2_target", int'(target), 0);
      push_exp("mid_rel_e3_target", 16);
      tick();
      pop_cmp(int'(target));
      repeat (10) tick();
      chk("mid_hold_target", int'(target), 16);
      up_pb = 1'b0;
      repeat (3) tick();

      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
